// File: rtl/bearing_resolver_if.sv
// Sample/result bundle for bearing_resolver: four microphone delay codes in,
// bearing and lock status out.
interface bearing_resolver_if #(
    parameter int CODE_W = 7,
    parameter int ANG_W  = 9
);
    logic              in_valid;
    logic [CODE_W-1:0] code_x1;
    logic [CODE_W-1:0] code_x2;
    logic [CODE_W-1:0] code_y1;
    logic [CODE_W-1:0] code_y2;
    logic              out_valid;
    logic [ANG_W-1:0]  theta;
    logic              lock;

    modport master (
        output in_valid, code_x1, code_x2, code_y1, code_y2,
        input  out_valid, theta, lock
    );

    modport slave (
        input  in_valid, code_x1, code_x2, code_y1, code_y2,
        output out_valid, theta, lock
    );
endinterface

// File: rtl/bearing_resolver.sv
// Three-stage bearing resolver: code-to-angle ROM, window test, bearing and lock update.
// Define BEARING_HOLD_EN to hold the last bearing on unresolved samples instead of all-ones.
module bearing_resolver #(
    parameter int    CODE_W     = 7,
    parameter int    LUT_W      = 7,
    parameter int    ANG_W      = 9,
    parameter int    WIN_LO     = 40,
    parameter int    WIN_HI     = 90,
    parameter int    OFFSET     = 1,
    parameter int    MISS_LIMIT = 8,
    parameter string LUT_FILE   = "lut.hex"
) (
    input logic               clock,
    input logic               reset_n,
    bearing_resolver_if.slave bus
);
    localparam int SUM_W = 10;
    localparam int DEPTH = 1 << CODE_W;
    localparam int X1 = 0;
    localparam int X2 = 1;
    localparam int Y1 = 2;
    localparam int Y2 = 3;

    localparam logic [LUT_W-1:0] WIN_LO_T     = LUT_W'(WIN_LO);
    localparam logic [LUT_W-1:0] WIN_HI_T     = LUT_W'(WIN_HI);
    localparam logic [SUM_W-1:0] OFFSET_T     = SUM_W'(OFFSET);
    localparam logic [SUM_W-1:0] DEG_90       = SUM_W'(90);
    localparam logic [SUM_W-1:0] DEG_180      = SUM_W'(180);
    localparam logic [SUM_W-1:0] DEG_270      = SUM_W'(270);
    localparam logic [SUM_W-1:0] DEG_360      = SUM_W'(360);
    localparam logic [7:0]       MISS_LIMIT_T = 8'(MISS_LIMIT);

    if (ANG_W < 9 || LUT_FILE == "") begin : g_bad_config
        $error("bearing_resolver: ANG_W must be at least 9 and LUT_FILE must name a table image");
    end

    // Inferred ROM holding the linear default image (entry i = i degrees); a vendor
    // ROM macro loaded from LUT_FILE drops in here.
    logic [LUT_W-1:0] rom [DEPTH];
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = LUT_W'(i);
    end

    logic [LUT_W-1:0] s1_t [4];
    logic [LUT_W-1:0] s2_t [4];
    logic             s1_blank;
    logic             s2_blank;
    logic [3:0]       s2_hit;
    logic             s1_valid;
    logic             s2_valid;
    logic             out_valid_q;
    logic [ANG_W-1:0] theta_q;
    logic [ANG_W-1:0] theta_miss;
    logic             lock_q;
    logic [7:0]       miss_cnt;
    logic [7:0]       miss_next;
    logic             resolved;
    logic [SUM_W-1:0] ax1, ax2, ay1, ay2;
    logic [SUM_W-1:0] base;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] bearing;

    // Datapath registers carry no reset; only the valid bits decide what reaches the output.
    always_ff @(posedge clock) begin
        s1_t[X1] <= rom[bus.code_x1];
        s1_t[X2] <= rom[bus.code_x2];
        s1_t[Y1] <= rom[bus.code_y1];
        s1_t[Y2] <= rom[bus.code_y2];
        s1_blank <= &{bus.code_x1, bus.code_x2, bus.code_y1, bus.code_y2};
        for (int k = 0; k < 4; k++) begin
            s2_t[k]   <= s1_t[k];
            s2_hit[k] <= (s1_t[k] >= WIN_LO_T) && (s1_t[k] <= WIN_HI_T);
        end
        s2_blank <= s1_blank;
    end

    // The first in-window axis (x1, x2, y1, y2) picks the quadrant formula; the other
    // axis sign disambiguates the half-plane.
    always_comb begin
        ax1      = SUM_W'(s2_t[X1]);
        ax2      = SUM_W'(s2_t[X2]);
        ay1      = SUM_W'(s2_t[Y1]);
        ay2      = SUM_W'(s2_t[Y2]);
        base     = '0;
        resolved = 1'b1;
        if (s2_blank)        resolved = 1'b0;
        else if (s2_hit[X1]) base = (ay2 != '0) ? ax1 : DEG_360 - ax1;
        else if (s2_hit[X2]) base = (ay2 != '0) ? DEG_180 - ax2 : DEG_180 + ax2;
        else if (s2_hit[Y1]) base = (ax1 != '0) ? DEG_270 + ay1 : DEG_270 - ay1;
        else if (s2_hit[Y2]) base = (ax1 != '0) ? DEG_90 - ay2 : DEG_90 + ay2;
        else                 resolved = 1'b0;
        sum       = base + OFFSET_T;
        bearing   = (sum >= DEG_360) ? sum - DEG_360 : sum;
        miss_next = (miss_cnt == 8'hFF) ? miss_cnt : miss_cnt + 8'd1;
    end

`ifdef BEARING_HOLD_EN
    assign theta_miss = theta_q;
`else
    assign theta_miss = '1;
`endif

    // Valid pipeline and the output/lock state; reset flushes anything in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            out_valid_q <= 1'b0;
            theta_q     <= '1;
            lock_q      <= 1'b0;
            miss_cnt    <= '0;
        end else begin
            s1_valid    <= bus.in_valid;
            s2_valid    <= s1_valid;
            out_valid_q <= s2_valid;
            if (s2_valid) begin
                if (resolved) begin
                    theta_q  <= ANG_W'(bearing);
                    lock_q   <= 1'b1;
                    miss_cnt <= '0;
                end else begin
                    miss_cnt <= miss_next;
                    if (miss_next >= MISS_LIMIT_T) begin
                        lock_q  <= 1'b0;
                        theta_q <= '1;
                    end else begin
                        theta_q <= theta_miss;
                    end
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.theta     = theta_q;
    assign bus.lock      = lock_q;
endmodule

// File: doc/bearing_resolver.md
BEARING_RESOLVER -- requirements
Module: bearing_resolver

Interface
REQ-001 Parameter CODE_W, default 7, width of each time-difference code.
REQ-002 Parameter LUT_W, default 7, width of each per-axis angle word in degrees.
REQ-003 Parameter ANG_W, default 9, width of the output bearing; it SHALL be at least 9.
REQ-004 Parameters WIN_LO and WIN_HI, defaults 40 and 90, set the inclusive in-range window for an axis angle.
REQ-005 Parameter OFFSET, default 1, is a bearing offset in degrees, range 0..359.
REQ-006 Parameter MISS_LIMIT, default 8, is the number of consecutive unresolved samples before loss of lock, range 1..255.
REQ-007 Parameter LUT_FILE, default "lut.hex", is the hex image of the code-to-angle table, 2^CODE_W entries of LUT_W bits.
REQ-008 Port clock, input, 1 bit: the single clock; all state SHALL change on its rising edge except under reset.
REQ-009 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 Port in_valid, input, 1 bit: the four codes are valid this cycle.
REQ-011 Ports code_x1, code_x2, code_y1 and code_y2, inputs, CODE_W bits each: per-microphone delay codes; all-ones means no arrival.
REQ-012 Port out_valid, input-to-output pulse, output, 1 bit: theta and lock are updated this cycle.
REQ-013 Port theta, output, ANG_W bits: bearing in degrees 0..359; all-ones means unresolved.
REQ-014 Port lock, output, 1 bit: high while a recent sample has resolved.

Function
REQ-015 The block SHALL be a 3-stage pipeline, with out_valid asserted exactly 3 cycles after in_valid and one result per in_valid, and no backpressure.
- Stage 1: synchronous ROM read of four angles, t_x1, t_x2, t_y1 and t_y2.
- Stage 2: register the angles and compute the in-range flags (WIN_LO <= t <= WIN_HI).
- Stage 3: resolve the bearing and update the output and lock state.
REQ-016 Resolution SHALL use priority x1 > x2 > y1 > y2 over the in-range flags:
- x1 in range: base = t_y2>0 ? t_x1 : 360−t_x1.
- x2 in range: base = t_y2>0 ? 180−t_x2 : 180+t_x2.
- y1 in range: base = t_x1>0 ? 270+t_y1 : 270−t_y1.
- y2 in range: base = t_x1>0 ? 90−t_y2 : 90+t_y2.
REQ-017 The resolved theta SHALL be (base+OFFSET) mod 360, computed in at least 10 bits, so that 360+1 wraps to 1 and 359+1 wraps to 0.
REQ-018 A sample with no axis in range, or with all four codes equal to all-ones, SHALL be unresolved.
REQ-019 A resolved sample SHALL set theta to the new bearing, set lock=1 and clear the miss counter.
REQ-020 An unresolved sample SHALL increment the saturating miss counter.
- If the incremented count reaches MISS_LIMIT, lock SHALL become 0 and theta all-ones in that same cycle.
- Otherwise, theta SHALL follow REQ-032.
REQ-021 In cycles without out_valid, theta, lock and the miss counter SHALL hold their values.
REQ-022 Back-to-back in_valid on every cycle SHALL sustain one result per cycle with no sample dropped.
REQ-023 Pipeline valid bits SHALL advance every cycle regardless of in_valid.

Reset
REQ-024 Assertion of reset_n=0 SHALL immediately clear the pipeline valids and out_valid, set theta to all-ones, clear lock, and clear the miss counter.
REQ-025 Samples in flight when reset asserts SHALL be discarded, and out_valid SHALL NOT pulse for them after release.
REQ-026 The ROM contents SHALL NOT be reset.
REQ-027 The first in_valid accepted after reset_n rises SHALL produce out_valid 3 cycles later.

Configuration
REQ-028 Macro BEARING_HOLD_EN SHALL select the unresolved-sample behaviour before MISS_LIMIT is reached.
REQ-029 With BEARING_HOLD_EN defined, theta SHALL hold the last resolved bearing.
REQ-030 Without BEARING_HOLD_EN, theta SHALL be all-ones on every unresolved sample.
REQ-031 The lock behaviour and the miss counter SHALL be the same in both builds.
REQ-032 The theta value defined by REQ-028 to REQ-030 SHALL apply to unresolved samples below MISS_LIMIT.

Verification
REQ-033 Reset, then t_x1=45 and t_y2=10 on the other axes:
- theta=46 and lock=1.
- out_valid exactly 3 cycles after in_valid.
REQ-034 t_x1=0 (not in range) and t_x2=60 with t_y2=0: theta=241. Then t_y1=50 with t_x1=0: theta=221.
REQ-035 Wrap: t_x1=40 with t_y2=0, OFFSET=321: base 320, 320+321=641, theta=281. Also OFFSET=1 with base 359: theta=0.
REQ-036 Resolve at theta=46, then 7 all-ones samples with MISS_LIMIT=8:
- With BEARING_HOLD_EN: theta=46 and lock=1.
- Without BEARING_HOLD_EN: theta=511 and lock=1.
- On the 8th sample, both builds: theta=511 and lock=0.
REQ-037 Apply 4 consecutive in_valid cycles, then assert reset_n low after the 2nd:
- No out_valid is produced.
- theta=511 and lock=0 immediately.
- The next sample after release resolves normally.
REQ-038 A continuous in_valid stream of 100 random codes SHALL yield 100 out_valid pulses, each matching a reference model applied to the same codes delayed 3 cycles.
